reg_file_multi: RTL and testbench

- Parametrised successor to the single load-enable register: a bank of NREGS registers of WIDTH bits.
- Provides one write port with op modes (load, increment, decrement, clear) and two independent read ports.
- Registered carry/zero flags from the last write-port operation.
- Serves as the A/B/temp register set and program-counter store of the 8-bit CPU datapath.

---
 rtl/reg_file_multi.sv | 90 +++++++++
 tb/tb_reg_file_multi.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_multi.sv
// reg_file_multi: NREGS x WIDTH register bank with one op-mode write port
// (LOAD/INC/DEC/CLR), two combinational read ports and registered carry/zero
// flags from the last accepted write.
// Optional feature: define REG_FILE_MULTI_BYPASS_EN to forward the value being
// written to a read port that addresses the write target in the same cycle.
module reg_file_multi #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             WEN,
  input  logic [1:0]       OP,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdat,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdat_a,
  output logic [WIDTH-1:0] rdat_b,
  output logic             carry,
  output logic             zero
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             carry_q;
  logic             zero_q;

  logic             accept_d;
  logic [WIDTH-1:0] old_d;
  logic [WIDTH:0]   result_d;

  // Decode the write op: accept only in-range targets and compute the
  // WIDTH+1 bit result whose top bit is the carry/borrow.
  always_comb begin
    accept_d = WEN && ({1'b0, waddr} < NREGS_W);
    old_d    = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (waddr == AW'(i)) old_d = regs_q[i];
    end
    case (OP)
      OP_LOAD: result_d = {1'b0, wdat};
      OP_INC:  result_d = {1'b0, old_d} + (WIDTH+1)'(1);
      OP_DEC:  result_d = {1'b0, old_d} - (WIDTH+1)'(1);
      OP_CLR:  result_d = '0;
      default: result_d = '0;
    endcase
  end

  // Register bank and flags; only accepted ops change state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept_d) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (waddr == AW'(i)) regs_q[i] <= result_d[WIDTH-1:0];
      end
      carry_q <= result_d[WIDTH];
      zero_q  <= (result_d[WIDTH-1:0] == '0);
    end
  end

  // Read ports: stored value, 0 for out-of-range addresses, optional bypass.
  always_comb begin
    rdat_a = '0;
    rdat_b = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (raddr_a == AW'(i)) rdat_a = regs_q[i];
      if (raddr_b == AW'(i)) rdat_b = regs_q[i];
    end
`ifdef REG_FILE_MULTI_BYPASS_EN
    if (accept_d && (raddr_a == waddr)) rdat_a = result_d[WIDTH-1:0];
    if (accept_d && (raddr_b == waddr)) rdat_b = result_d[WIDTH-1:0];
`else
`endif
  end

  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_reg_file_multi.sv
// Directed self-checking bench for reg_file_multi: a 4-register instance and a
// 3-register instance (for out-of-range writes/reads) share all inputs.
module tb_reg_file_multi;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] DEC  = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       WEN;
  logic [1:0] OP;
  logic [1:0] waddr;
  logic [7:0] wdat;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [7:0] rdat_a, rdat_b, rdat3_a, rdat3_b;
  logic       carry, zero, carry3, zero3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  reg_file_multi #(.WIDTH(8), .NREGS(4)) u_dut (
    .CLK(CLK), .nRST(nRST), .WEN(WEN), .OP(OP), .waddr(waddr), .wdat(wdat),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdat_a(rdat_a), .rdat_b(rdat_b),
    .carry(carry), .zero(zero)
  );

  reg_file_multi #(.WIDTH(8), .NREGS(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .WEN(WEN), .OP(OP), .waddr(waddr), .wdat(wdat),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdat_a(rdat3_a), .rdat_b(rdat3_b),
    .carry(carry3), .zero(zero3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One accepted-or-not write cycle; WEN is dropped afterwards so that a
  // bypass build shows stored values at the post-edge check.
  task automatic do_op(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
    WEN = 1'b1; OP = op; waddr = a; wdat = d;
    @(posedge CLK); #1;
    WEN = 1'b0;
    #1;
  endtask

  initial begin
    nRST = 1'b0; WEN = 1'b0; OP = LOAD; waddr = '0; wdat = '0;
    raddr_a = '0; raddr_b = '0;

    // Reset for two cycles, release away from the edge
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    for (int a = 0; a < 4; a++) begin
      raddr_a = 2'(a); raddr_b = 2'(3 - a); #1;
      chk($sformatf("rst_rdat_a[%0d]", a), rdat_a, 8'h00);
      chk($sformatf("rst_rdat_b[%0d]", 3 - a), rdat_b, 8'h00);
    end
    chk("rst_carry", 8'(carry), 8'h00);
    chk("rst_zero", 8'(zero), 8'h00);

    // Load and dual read
    do_op(LOAD, 2'd1, 8'h5A);
    do_op(LOAD, 2'd2, 8'hC3);
    raddr_a = 2'd1; raddr_b = 2'd2; #1;
    chk("load_rdat_a", rdat_a, 8'h5A);
    chk("load_rdat_b", rdat_b, 8'hC3);
    chk("load_carry", 8'(carry), 8'h00);
    chk("load_zero", 8'(zero), 8'h00);
    chk("load3_rdat_b", rdat3_b, 8'hC3);
    raddr_b = 2'd1; #1;
    chk("same_addr_b", rdat_b, 8'h5A);
    do_op(LOAD, 2'd1, 8'h00);
    chk("load0_rdat_a", rdat_a, 8'h00);
    chk("load0_zero", 8'(zero), 8'h01);
    chk("load0_carry", 8'(carry), 8'h00);

    // Async reset mid-cycle after loads
    do_op(LOAD, 2'd1, 8'h5A);
    raddr_a = 2'd1; raddr_b = 2'd2; #1;
    chk("pre_arst_rdat_a", rdat_a, 8'h5A);
    nRST = 1'b0; #1;
    chk("arst_rdat_a", rdat_a, 8'h00);
    chk("arst_rdat_b", rdat_b, 8'h00);
    chk("arst_carry", 8'(carry), 8'h00);
    chk("arst_zero", 8'(zero), 8'h00);
    @(negedge CLK); nRST = 1'b1;

    // Increment wrap on r0
    raddr_a = 2'd0;
    do_op(LOAD, 2'd0, 8'hFE);
    do_op(INC, 2'd0, 8'h00);
    chk("inc1_r0", rdat_a, 8'hFF);
    chk("inc1_carry", 8'(carry), 8'h00);
    chk("inc1_zero", 8'(zero), 8'h00);
    do_op(INC, 2'd0, 8'h00);
    chk("inc2_r0", rdat_a, 8'h00);
    chk("inc2_carry", 8'(carry), 8'h01);
    chk("inc2_zero", 8'(zero), 8'h01);

    // Decrement borrow on r3 (ignored by the 3-register instance)
    raddr_a = 2'd3;
    do_op(CLR, 2'd3, 8'h00);
    chk("clr_r3", rdat_a, 8'h00);
    chk("clr_zero", 8'(zero), 8'h01);
    chk("clr_carry", 8'(carry), 8'h00);
    do_op(DEC, 2'd3, 8'h00);
    chk("dec1_r3", rdat_a, 8'hFF);
    chk("dec1_carry", 8'(carry), 8'h01);
    chk("dec1_zero", 8'(zero), 8'h00);
    do_op(DEC, 2'd3, 8'h00);
    chk("dec2_r3", rdat_a, 8'hFE);
    chk("dec2_carry", 8'(carry), 8'h00);
    chk("dec2_zero", 8'(zero), 8'h00);

    // Out-of-range write on NREGS=3: flags still from the last INC wrap
    do_op(LOAD, 2'd3, 8'h77);
    raddr_a = 2'd3; raddr_b = 2'd0; #1;
    chk("oor3_rdat_a", rdat3_a, 8'h00);
    chk("oor3_rdat_b", rdat3_b, 8'h00);
    chk("oor3_carry", 8'(carry3), 8'h01);
    chk("oor3_zero", 8'(zero3), 8'h01);
    chk("oor4_r3", rdat_a, 8'h77);

    // WEN=0 with CLR holds everything
    WEN = 1'b0; OP = CLR; waddr = 2'd3;
    @(posedge CLK); #1;
    chk("hold_r3", rdat_a, 8'h77);
    chk("hold_carry", 8'(carry), 8'h00);
    chk("hold_zero", 8'(zero), 8'h00);

    // Bypass: INC r1 while reading r1 on port A
    do_op(LOAD, 2'd1, 8'h10);
    raddr_a = 2'd1; raddr_b = 2'd0;
    WEN = 1'b1; OP = INC; waddr = 2'd1; #1;
`ifdef REG_FILE_MULTI_BYPASS_EN
    chk("byp_pre_a", rdat_a, 8'h11);
`else
    chk("byp_pre_a", rdat_a, 8'h10);
`endif
    chk("byp_pre_b", rdat_b, 8'h00);
    @(posedge CLK); #1;
    WEN = 1'b0; #1;
    chk("byp_post_a", rdat_a, 8'h11);
    chk("byp_post_carry", 8'(carry), 8'h00);
    chk("byp_post_zero", 8'(zero), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
